// File: rtl/pipe_reg_chain.sv
// N-stage pipeline register chain with per-stage valid, global advance enable,
// backward-propagating stall, per-stage flush and bubble insertion behind a stall.
// Optional macro PIPE_REG_CHAIN_PERF_EN adds bubble_cnt/stall_cnt counters.
module pipe_reg_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      en,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES*WIDTH-1:0]   dout,
  output logic [STAGES-1:0]         vout,
  output logic [OCC_W-1:0]          occ
`ifdef PIPE_REG_CHAIN_PERF_EN
  ,
  output logic [31:0]               bubble_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic [STAGES-1:0]            hold;

  // A stall anywhere at or beyond stage i freezes stage i.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = ~en | stall[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      hold[i] = hold[i+1] | stall[i];
    end
  end

  assign din_ready = ~hold[0];

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush[0]) begin
      data_d[0]  = '0;
      valid_d[0] = 1'b0;
    end else if (!hold[0]) begin
      data_d[0]  = din;
      valid_d[0] = din_valid;
    end
    // A stage that may advance while its predecessor is held receives a bubble.
    for (int i = 1; i < STAGES; i++) begin
      if (flush[i] || (!hold[i] && hold[i-1])) begin
        data_d[i]  = '0;
        valid_d[i] = 1'b0;
      end else if (!hold[i]) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      data_q  <= '0;
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  assign dout = data_q;
  assign vout = valid_q;
  assign occ  = occ_q;

`ifdef PIPE_REG_CHAIN_PERF_EN
  logic [31:0] bubble_cnt_q, stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (en && !valid_d[STAGES-1]) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (|stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a behavioural model.
module tb_pipe_reg_chain;
  localparam int W  = 32;
  localparam int S  = 4;
  localparam int OW = $clog2(S + 1);

  logic          CLK = 1'b0;
  logic          nRST;
  logic          en;
  logic          dinValid;
  logic [W-1:0]  din;
  logic [S-1:0]  stall;
  logic [S-1:0]  flush;
  logic          dinReady;
  logic [S*W-1:0] dout;
  logic [S-1:0]  vout;
  logic [OW-1:0] occ;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  logic [W-1:0] md[S];
  logic         mv[S];
  logic [31:0]  expBubble;
  logic [31:0]  expStall;

`ifdef PIPE_REG_CHAIN_PERF_EN
  logic [31:0] bubbleCnt;
  logic [31:0] stallCnt;
`endif

  pipe_reg_chain #(.WIDTH(W), .STAGES(S)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .din(din), .din_valid(dinValid),
    .din_ready(dinReady), .stall(stall), .flush(flush),
    .dout(dout), .vout(vout), .occ(occ)
`ifdef PIPE_REG_CHAIN_PERF_EN
    , .bubble_cnt(bubbleCnt), .stall_cnt(stallCnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Stage i is frozen when the chain is disabled or any stage at or after i stalls.
  function automatic bit frozen(input int i);
    return !en || ((stall >> i) != '0);
  endfunction

  function automatic logic [S-1:0] modelValid();
    logic [S-1:0] v;
    for (int i = 0; i < S; i++) v[i] = mv[i];
    return v;
  endfunction

  function automatic int modelOcc();
    int n = 0;
    for (int i = 0; i < S; i++) if (mv[i]) n++;
    return n;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    if (!nRST) begin
      for (int i = 0; i < S; i++) begin
        md[i] = '0;
        mv[i] = 1'b0;
      end
      expBubble = '0;
      expStall  = '0;
    end else begin
      for (int i = S - 1; i >= 0; i--) begin
        if (flush[i]) begin
          md[i] = '0;
          mv[i] = 1'b0;
        end else if (frozen(i)) begin
          md[i] = md[i];
        end else if (i == 0) begin
          md[0] = din;
          mv[0] = dinValid;
        end else if (frozen(i - 1)) begin
          md[i] = '0;
          mv[i] = 1'b0;
        end else begin
          md[i] = md[i-1];
          mv[i] = mv[i-1];
        end
      end
      if (en && !mv[S-1]) expBubble = expBubble + 32'd1;
      if (stall != '0) expStall = expStall + 32'd1;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit v, input logic [W-1:0] d,
                               input logic [S-1:0] st, input logic [S-1:0] fl);
    nRST = r; en = e; dinValid = v; din = d; stall = st; flush = fl;
    @(posedge CLK);
    modelEdge();
    #2;
  endtask

  // Outputs are compared against the model midway through every cycle.
  always @(negedge CLK) begin
    if (checkEn) begin
      for (int i = 0; i < S; i++)
        checkOutput($sformatf("dout%0d", i), 64'(dout[i*W +: W]), 64'(md[i]));
      checkOutput("vout", 64'(vout), 64'(modelValid()));
      checkOutput("occ", 64'(occ), 64'(modelOcc()));
      checkOutput("din_ready", 64'(dinReady), 64'(en && stall == '0));
`ifdef PIPE_REG_CHAIN_PERF_EN
      checkOutput("bubble_cnt", 64'(bubbleCnt), 64'(expBubble));
      checkOutput("stall_cnt", 64'(stallCnt), 64'(expStall));
`endif
    end
  end

  task automatic fillChain(input logic [W-1:0] base);
    for (int k = 0; k < S; k++) applyStimulus(1'b1, 1'b1, 1'b1, base + W'(k), '0, '0);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, '1, '1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    checkEn = 1'b1;
    checkOutput("lit_reset_vout", 64'(vout), 64'd0);
    checkOutput("lit_reset_occ", 64'(occ), 64'd0);
    checkOutput("lit_reset_dout", 64'(dout), 64'd0);

    // Streaming: latency of one cycle per stage.
    for (int k = 1; k <= 4; k++) applyStimulus(1'b1, 1'b1, 1'b1, W'(k), '0, '0);
    checkOutput("lit_stream_s3", 64'(dout[3*W +: W]), 64'd1);
    checkOutput("lit_stream_s0", 64'(dout[0 +: W]), 64'd4);
    checkOutput("lit_stream_vout", 64'(vout), 64'hF);
    checkOutput("lit_stream_occ", 64'(occ), 64'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd5, '0, '0);
    checkOutput("lit_stream_s3_next", 64'(dout[3*W +: W]), 64'd2);

    // Stall at stage 1 for two edges.
    fillChain(32'd5);
    nRST = 1'b1; en = 1'b1; stall = 4'b0010; flush = '0; #1;
    checkOutput("lit_stall_ready", 64'(dinReady), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd9, 4'b0010, '0);
    checkOutput("lit_stall_s0", 64'(dout[0 +: W]), 64'd8);
    checkOutput("lit_stall_s1", 64'(dout[W +: W]), 64'd7);
    checkOutput("lit_stall_s3", 64'(dout[3*W +: W]), 64'd6);
    checkOutput("lit_stall_vout", 64'(vout), 64'b1011);
    checkOutput("lit_stall_occ1", 64'(occ), 64'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd9, 4'b0010, '0);
    checkOutput("lit_stall_vout2", 64'(vout), 64'b0011);
    checkOutput("lit_stall_occ2", 64'(occ), 64'd2);

    // Flush together with a stall at stage 2.
    fillChain(32'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd9, 4'b0100, 4'b0100);
    checkOutput("lit_flush_vout", 64'(vout), 64'b0011);
    checkOutput("lit_flush_s2", 64'(dout[2*W +: W]), 64'd0);
    checkOutput("lit_flush_s1", 64'(dout[W +: W]), 64'd7);
    checkOutput("lit_flush_occ", 64'(occ), 64'd2);

    // Global freeze with a flush pulse on stage 0.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd100, '0, '0);
    checkOutput("lit_freeze_s0", 64'(dout[0 +: W]), 64'd8);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd101, '0, 4'b0001);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd102, '0, '0);
    checkOutput("lit_freeze_vout", 64'(vout), 64'b0010);
    checkOutput("lit_freeze_s1", 64'(dout[W +: W]), 64'd7);

    // Mid-stream reset overrides stall, then the stream resumes.
    fillChain(32'd20);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'd55, 4'b1111, '0);
    checkOutput("lit_midrst_vout", 64'(vout), 64'd0);
    checkOutput("lit_midrst_dout", 64'(dout), 64'd0);
    checkOutput("lit_midrst_occ", 64'(occ), 64'd0);
    fillChain(32'd30);
    checkOutput("lit_resume_s3", 64'(dout[3*W +: W]), 64'd30);
    checkOutput("lit_resume_occ", 64'(occ), 64'd4);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 7) != 0,
                    1'($urandom), W'($urandom),
                    ($urandom_range(0, 3) == 0) ? S'($urandom) : '0,
                    ($urandom_range(0, 5) == 0) ? S'($urandom) : '0);
    end

    // Performance counter scenario.
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b1, 1'b0, W'(k), '0, '0);
`ifdef PIPE_REG_CHAIN_PERF_EN
    checkOutput("lit_perf_bubble", 64'(bubbleCnt), 64'd10);
    checkOutput("lit_perf_stall0", 64'(stallCnt), 64'd0);
`endif
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 4'b1000, '0);
`ifdef PIPE_REG_CHAIN_PERF_EN
    checkOutput("lit_perf_stall", 64'(stallCnt), 64'd3);
`endif
    checkOutput("lit_perf_vout", 64'(vout), 64'd0);

    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
